bcd_counter: RTL and testbench
==============================

// Module: bcd_counter
// PURPOSE
//  - Single-digit, free-running, synchronous BCD (decimal) counter: 0,1,...,9,0,...
//  - Leaf block for decimal displays/timers; cascade via the optional carry output.
//  - Counts on every rising clk edge; there is no enable input.
// PARAMETERS
//  - RESET_VALUE  4'd0  digit loaded on reset; legal range 0..9.
//  - WRAP_VALUE   4'd9  last digit before wrapping to 0; legal range 1..9.
// PORTS
//  - clk    in   1  rising-edge clock; the only clock.
//  - rst    in   1  synchronous, active-high reset.
//  - bcd    out  4  current BCD digit, driven directly from a register.
//  - carry  out  1  wrap pulse; present only when BCD_COUNTER_CARRY_EN is defined.
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst); there is no async path.
//  - Every rising clk edge, in priority order:
//    1. rst=1 -> bcd <= RESET_VALUE. Reset wins over counting.
//    2. else bcd==WRAP_VALUE -> bcd <= 0.
//    3. else bcd > WRAP_VALUE (an illegal code, e.g. 10..15) -> bcd <= 0 (self-recovery in 1 cycle).
//    4. else bcd <= bcd + 1.
//  - Reset value: bcd = RESET_VALUE (0); carry = 0.
//  - Latency: bcd changes 1 cycle after the edge that samples rst; outputs are registered, no comb path.
//  - Reset mid-count: the next edge with rst=1 forces RESET_VALUE, whatever the current digit.
//  - Releasing rst: the first edge with rst=0 advances to RESET_VALUE+1.
//  - rst held for N edges: bcd stays at RESET_VALUE for all N edges.
//  - Power-up without reset: register content is undefined. No X-pessimism fix is required.
//    Once the value is known, rule 3 guarantees a legal digit within 1 cycle.
//  - Arithmetic: 4-bit unsigned increment. 4'd15+1 never reaches the register (rule 3 catches it).
// CONFIGURATION
//  - Macro BCD_COUNTER_CARRY_EN:
//    - Defined: adds registered output `carry`.
//      - carry=1 for exactly the one cycle in which bcd transitions WRAP_VALUE->0
//        (set on the same edge as the wrap).
//      - carry=0 on reset and on illegal-code recovery.
//    - Undefined: port `carry` does not exist; everything else is identical.
// STRUCTURE
//  - Package bcd_counter_pkg:
//    - typedef logic [3:0] bcd_t;
//    - localparam bcd_t BCD_ZERO=4'd0, BCD_MAX=4'd9.
//    - function is_legal_bcd(bcd_t).
//  - Sub-module bcd_digit_next (combinational): inputs cur, wrap; outputs nxt, wrapped.
//    It implements rules 2-4.
//  - Top module: the register, reset mux, optional carry register, and parameter-range
//    elaboration checks.
// TESTING
//  - Reset then count: rst=1 for 1 edge -> bcd=0. Then 12 edges -> 1,2,...,9,0,1,2.
//  - Wrap: from bcd=9 one edge -> bcd=0. With CARRY_EN, carry=1 that cycle only,
//    0 on the next.
//  - Reset mid-count: at bcd=5 assert rst for 1 edge -> bcd=0. Release -> next edge bcd=1.
//  - Held reset: rst=1 for 5 edges -> bcd=0 throughout, carry=0.
//  - Illegal recovery: force the register to 4'd12 (and 4'd15), rst=0, one edge ->
//    bcd=0, carry=0.
//  - Parameters: RESET_VALUE=3, WRAP_VALUE=5, reset then 6 edges -> 4,5,0,1,2,3.

Source files
------------

// File: rtl/bcd_counter_pkg.sv
// Shared types, constants and helpers for the single-digit BCD counter.
// Imported by bcd_digit_next and bcd_counter.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_ZERO = 4'd0;
    localparam bcd_t BCD_MAX  = 4'd9;

    function automatic logic is_legal_bcd(bcd_t value);
        return (value <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_next.sv
// Combinational next-digit logic: wraps at `wrap` and recovers from any code above it.
// Priority: exact wrap first, then out-of-range recovery, then plain increment.
module bcd_digit_next
    import bcd_counter_pkg::*;
(
    input  logic [3:0] cur,
    input  logic [3:0] wrap,
    output logic [3:0] nxt,
    output logic       wrapped
);

    // Only a true wrap reports `wrapped`; illegal-code recovery stays silent.
    always_comb begin
        nxt     = cur + 4'd1;
        wrapped = 1'b0;
        if (cur == wrap) begin
            nxt     = BCD_ZERO;
            wrapped = 1'b1;
        end else if (cur > wrap) begin
            nxt     = BCD_ZERO;
        end
    end

endmodule

// File: rtl/bcd_counter.sv
// Free-running single-digit BCD counter with synchronous reset.
// Define BCD_COUNTER_CARRY_EN to add the registered one-cycle `carry` wrap pulse.
module bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter logic [3:0] RESET_VALUE = 4'd0,
    parameter logic [3:0] WRAP_VALUE  = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
`ifdef BCD_COUNTER_CARRY_EN
    output logic       carry,
`endif
    output logic [3:0] bcd
);

    if (!is_legal_bcd(RESET_VALUE)) begin : g_bad_reset_value
        $error("bcd_counter: RESET_VALUE must be in 0..9");
    end
    if (WRAP_VALUE == BCD_ZERO || !is_legal_bcd(WRAP_VALUE)) begin : g_bad_wrap_value
        $error("bcd_counter: WRAP_VALUE must be in 1..9");
    end

    logic [3:0] bcd_q;
    logic [3:0] bcd_d;
    logic [3:0] nxt;
    logic       wrapped;

    bcd_digit_next u_next (
        .cur     (bcd_q),
        .wrap    (WRAP_VALUE),
        .nxt     (nxt),
        .wrapped (wrapped)
    );

    // Reset has priority over counting.
    always_comb begin
        bcd_d = nxt;
        if (rst) begin
            bcd_d = RESET_VALUE;
        end
    end

    always_ff @(posedge clk) begin
        bcd_q <= bcd_d;
    end

    assign bcd = bcd_q;

`ifdef BCD_COUNTER_CARRY_EN
    logic carry_q;
    logic carry_d;

    always_comb begin
        carry_d = wrapped;
        if (rst) begin
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        carry_q <= carry_d;
    end

    assign carry = carry_q;
`else
    logic unused_wrapped;
    assign unused_wrapped = wrapped;
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// Scoreboard bench for bcd_counter: stimulus queues expected digits, a monitor checks each cycle.
// Three instances cover default, RESET_VALUE=3/WRAP_VALUE=5, and out-of-range recovery (8 vs wrap 5).
module tb_bcd_counter;

    typedef struct {
        int         dut;
        logic [3:0] bcd;
        logic       carry;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic       rst_c = 1'b0;
    logic [3:0] bcd_a;
    logic [3:0] bcd_b;
    logic [3:0] bcd_c;
    logic       carry_a;
    logic       carry_b;
    logic       carry_c;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef BCD_COUNTER_CARRY_EN
    bcd_counter dut_a (.clk(clk), .rst(rst_a), .carry(carry_a), .bcd(bcd_a));
    bcd_counter #(.RESET_VALUE(4'd3), .WRAP_VALUE(4'd5))
        dut_b (.clk(clk), .rst(rst_b), .carry(carry_b), .bcd(bcd_b));
    bcd_counter #(.RESET_VALUE(4'd8), .WRAP_VALUE(4'd5))
        dut_c (.clk(clk), .rst(rst_c), .carry(carry_c), .bcd(bcd_c));
`else
    bcd_counter dut_a (.clk(clk), .rst(rst_a), .bcd(bcd_a));
    bcd_counter #(.RESET_VALUE(4'd3), .WRAP_VALUE(4'd5))
        dut_b (.clk(clk), .rst(rst_b), .bcd(bcd_b));
    bcd_counter #(.RESET_VALUE(4'd8), .WRAP_VALUE(4'd5))
        dut_c (.clk(clk), .rst(rst_c), .bcd(bcd_c));
    assign carry_a = 1'b0;
    assign carry_b = 1'b0;
    assign carry_c = 1'b0;
`endif

    // Drive one edge's worth of stimulus on the falling edge and queue what the next rising edge must produce.
    task automatic applyStimulus(input int dut, input logic rst_val, input logic [3:0] exp_bcd,
                                 input logic exp_carry, input string name);
        exp_t e;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        case (dut)
            0: rst_a = rst_val;
            1: rst_b = rst_val;
            default: rst_c = rst_val;
        endcase
        e.dut   = dut;
        e.bcd   = exp_bcd;
        e.carry = exp_carry;
        e.name  = name;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] act_bcd;
        logic       act_carry;
        case (e.dut)
            0: begin act_bcd = bcd_a; act_carry = carry_a; end
            1: begin act_bcd = bcd_b; act_carry = carry_b; end
            default: begin act_bcd = bcd_c; act_carry = carry_c; end
        endcase
        checks++;
        if (act_bcd !== e.bcd) begin
            errors++;
            $display("[TB] FAIL %s bcd: got %0d expected %0d", e.name, act_bcd, e.bcd);
        end
`ifdef BCD_COUNTER_CARRY_EN
        checks++;
        if (act_carry !== e.carry) begin
            errors++;
            $display("[TB] FAIL %s carry: got %0b expected %0b", e.name, act_carry, e.carry);
        end
`else
        if (act_carry !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s carry tie-off: got %0b expected 0", e.name, act_carry);
        end
`endif
    endtask

    // Monitor: every rising edge presents a new digit, so pop and compare just after it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                checkOutput(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0] seq_count [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                       4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        logic [3:0] seq_wrap  [11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                       4'd7, 4'd8, 4'd9, 4'd0, 4'd1};
        logic [3:0] seq_b     [6]  = '{4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};
        logic [3:0] seq_c     [7]  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
        int         budget;

        $display("[TB] start");

        // Reset then count through one wrap.
        applyStimulus(0, 1'b1, 4'd0, 1'b0, "reset");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1'b0, seq_count[i], (i == 9), "count");
        end

        // Reset mid-count at digit 5, then release.
        applyStimulus(0, 1'b0, 4'd3, 1'b0, "pre_mid");
        applyStimulus(0, 1'b0, 4'd4, 1'b0, "pre_mid");
        applyStimulus(0, 1'b0, 4'd5, 1'b0, "pre_mid");
        applyStimulus(0, 1'b1, 4'd0, 1'b0, "mid_reset");
        applyStimulus(0, 1'b0, 4'd1, 1'b0, "release");

        // Held reset.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1'b1, 4'd0, 1'b0, "held_reset");
        end

        // Wrap from 9 with a single-cycle carry.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(0, 1'b0, seq_wrap[i], (i == 9), "wrap");
        end

        // RESET_VALUE=3, WRAP_VALUE=5.
        applyStimulus(1, 1'b1, 4'd3, 1'b0, "param_reset");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1'b0, seq_b[i], (i == 2), "param_count");
        end

        // Reset to 8 with wrap 5: out-of-range code must recover to 0 with no carry.
        applyStimulus(2, 1'b1, 4'd8, 1'b0, "recover_reset");
        applyStimulus(2, 1'b1, 4'd8, 1'b0, "recover_reset");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(2, 1'b0, seq_c[i], (i == 6), "recover");
        end

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
